// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order pipeline.
// Resolves load-use hazards, taken branches and instruction/data memory
// back-pressure into per-stage hold enables and bubble (flush) requests.
// A small FSM remembers data-memory waits and wrong-path fetches that are
// still outstanding, so that a required IF/ID flush is never lost.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal operation, outputs follow hazard priority
// DWAIT | data memory busy, whole pipeline frozen
// FPEND | wrong-path fetch still in flight, IF/ID flushed until it returns
module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              im_stall,
    input  logic              dm_stall,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              stall_wb,
    output logic              flush_id,
    output logic              flush_ex,
    output logic [1:0]        ctrl_state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  dwait_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        FPEND = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   lu;

    // Load-use hazard: the EX load writes a register the ID instruction reads.
    always_comb begin
        lu = ex_mem_read && (ex_rd != '0) &&
             ((id_rs1_used && (id_rs1 == ex_rd)) ||
              (id_rs2_used && (id_rs2 == ex_rd)));
    end

    // State register, asynchronously returned to RUN on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next-state and hazard outputs by priority dm_stall > branch > lu > im_stall.
    always_comb begin
        state_nxt = RUN;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;

        if (dm_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            stall_wb  = 1'b1;
        end else if (ex_branch_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (lu) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end else if (im_stall) begin
            stall_if = 1'b1;
            flush_id = 1'b1;
        end

        case (state)
            RUN, DWAIT: begin
                if (dm_stall)
                    state_nxt = DWAIT;
                else if (ex_branch_taken && im_stall)
                    state_nxt = FPEND;
                else
                    state_nxt = RUN;
            end
            FPEND: begin
                // Frozen pipeline keeps the flush pending; otherwise keep
                // killing IF/ID until the wrong-path fetch has returned.
                if (dm_stall) begin
                    state_nxt = FPEND;
                end else begin
                    flush_id  = 1'b1;
                    state_nxt = im_stall ? FPEND : RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (rst) begin
            stall_if  = 1'b0;
            stall_id  = 1'b0;
            stall_ex  = 1'b0;
            stall_mem = 1'b0;
            stall_wb  = 1'b0;
            flush_id  = 1'b0;
            flush_ex  = 1'b0;
        end
    end

    assign ctrl_state = state;

    // Saturating performance counters for front-end stalls and data waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            dwait_cnt <= '0;
        end else begin
            if (stall_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (dm_stall && (dwait_cnt != '1)) dwait_cnt <= dwait_cnt + 1'b1;
        end
    end

endmodule
